adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// ============================================================================
//  Module      : adder_seq_ctrl
//  Description : Wide adder built from one BITS-wide slice adder reused once
//                per slice, LSB slice first.  Optional subtract mode is
//                enabled by defining ADDSEQ_SUB_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_seq_ctrl #(
    parameter int BITS  = 16,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef ADDSEQ_SUB_EN
    input  logic                  sub,
`endif
    input  logic [BITS*WORDS-1:0] a,
    input  logic [BITS*WORDS-1:0] b,
    input  logic                  c_i,
    output logic                  busy,
    output logic                  done,
    output logic [BITS*WORDS-1:0] s,
    output logic                  c_o
);

    localparam int W    = BITS * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(WORDS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_s;
    logic            r_co;

    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    w_b_load;
    logic            w_cin_load;
    logic [BITS:0]   w_sum;

    assign w_accept = (r_state == c_ST_IDLE) && start;
    assign w_last   = (r_state == c_ST_RUN) && (r_idx == c_LAST_IDX);

    // Subtraction is folded in at load time: A - B = A + ~B + 1.
`ifdef ADDSEQ_SUB_EN
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : c_i;
`else
    assign w_b_load   = b;
    assign w_cin_load = c_i;
`endif

    // The single slice adder; operands are shifted down so slice idx is always at the bottom.
    assign w_sum = {1'b0, r_a[BITS-1:0]} + {1'b0, r_b[BITS-1:0]} + {{BITS{1'b0}}, r_carry};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                busy = 1'b1;
            end
            c_ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_work  <= '0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_cin_load;
        end else if (r_state == c_ST_RUN) begin
            r_idx   <= r_idx + IDXW'(1);
            r_a     <= r_a >> BITS;
            r_b     <= r_b >> BITS;
            r_carry <= w_sum[BITS];
            // Slices enter at the top; after WORDS steps slice 0 sits at the bottom.
            r_work  <= {w_sum[BITS-1:0], r_work[W-1:BITS]};
        end
    end

    // Result registers change only on the edge that completes the top slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else if (w_last) begin
            r_s  <= {w_sum[BITS-1:0], r_work[W-1:BITS]};
            r_co <= w_sum[BITS];
        end
    end

    assign s   = r_s;
    assign c_o = r_co;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// ============================================================================
//  Module      : tb_adder_seq_ctrl
//  Description : Directed self-checking bench for adder_seq_ctrl (16 x 4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_seq_ctrl;

    localparam int BITS  = 16;
    localparam int WORDS = 4;
    localparam int W     = BITS * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_i;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_o;

    int errors;
    int checks;

    adder_seq_ctrl #(
        .BITS  (BITS),
        .WORDS (WORDS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_i   (c_i),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c_o   (c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; inputs are scrambled right after sampling.
    task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                          input logic ici, input logic [63:0] es, input logic ec);
        int busy_cnt;
        int done_cnt;
        int done_at;
        int early;
        logic [63:0] prev_s;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        early    = 0;
        @(negedge clk);
        prev_s = s;
        a      = ia;
        b      = ib;
        c_i    = ici;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        c_i   = ~ici;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end else if (busy && (s !== prev_s)) begin
                early++;
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd5);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_latency"}, 64'(done_at), 64'd5);
        check({tag, "_s_held_in_run"}, 64'(early), 64'd0);
        check({tag, "_s"}, s, es);
        check({tag, "_c_o"}, 64'(c_o), 64'(ec));
    endtask

    initial begin
        int done_pos [2];
        logic [63:0] done_s [2];
        int nd;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        c_i    = 1'b0;

        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_s", s, 64'd0);
        check("reset_c_o", 64'(c_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
        run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);
        run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h2222_2222_2222_2212, 1'b0);
        run_op("top_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0,
               64'h1, 1'b1);

        // start held high: accepted only from IDLE, a changed mid-run.
        nd = 0;
        done_pos[0] = 0;
        done_pos[1] = 0;
        done_s[0]   = '0;
        done_s[1]   = '0;
        @(negedge clk);
        a     = 64'h10;
        b     = 64'h20;
        c_i   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) a = 64'h999;
            if (done && nd < 2) begin
                done_pos[nd] = n;
                done_s[nd]   = s;
                nd++;
            end
            if (n == 11) start = 1'b0;
        end
        check("hold_done_count", 64'(nd), 64'd2);
        check("hold_first_at", 64'(done_pos[0]), 64'd5);
        check("hold_first_s", done_s[0], 64'h30);
        check("hold_spacing", 64'(done_pos[1] - done_pos[0]), 64'd6);
        check("hold_second_s", done_s[1], 64'h9B9);
        repeat (4) @(negedge clk);

        // Reset after two slices aborts the operation.
        @(negedge clk);
        a     = 64'h1111;
        b     = 64'h2222;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_s", s, 64'd0);
        check("abort_c_o", 64'(c_o), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_partial", s, 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        run_op("after_reset", 64'd3, 64'd5, 1'b0, 64'd8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
